// File: rtl/map_row_prefetch_pkg.sv
// Shared types and derivations for the map row prefetcher.
// Geometry helpers, FSM encoding and the 2-bit wall-ID type.
package map_row_prefetch_pkg;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned WALL_W = 2;

  typedef logic [WALL_W-1:0] wall_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Cells per map row.
  function automatic int unsigned map_width(input int unsigned wbits);
    return 32'd1 << wbits;
  endfunction

  // First line past the overlay window (one extra line so the last row is shown fully).
  function automatic int unsigned ovl_h(input int unsigned hbits, input int unsigned scale);
    return (32'd1 << (hbits + scale)) + 32'd1;
  endfunction

endpackage

// File: rtl/map_row_prefetch_if.sv
// Map ROM handshake and overlay read port of the map row prefetcher.
// master = prefetcher side, slave = ROM arbiter / overlay side.
interface map_row_prefetch_if
  import map_row_prefetch_pkg::*;
#(
  parameter int unsigned MAP_WBITS = 4,
  parameter int unsigned MAP_HBITS = 4
) ();

  logic                 o_rom_req;
  logic                 i_rom_gnt;
  logic [MAP_WBITS-1:0] o_rom_col;
  logic [MAP_HBITS-1:0] o_rom_row;
  wall_id_t             i_rom_val;
  logic [MAP_WBITS-1:0] i_ovl_col;
  wall_id_t             o_ovl_val;
  logic                 o_ovl_valid;

  modport master (
    output o_rom_req, o_rom_col, o_rom_row, o_ovl_val, o_ovl_valid,
    input  i_rom_gnt, i_rom_val, i_ovl_col
  );

  modport slave (
    input  o_rom_req, o_rom_col, o_rom_row, o_ovl_val, o_ovl_valid,
    output i_rom_gnt, i_rom_val, i_ovl_col
  );

endinterface

// File: rtl/map_row_prefetch_buffer.sv
// map_row_buffer: one map row of wall IDs with a single write port,
// a bulk load (row promote) and a combinational read mux.
module map_row_buffer
  import map_row_prefetch_pkg::*;
#(
  parameter  int unsigned MAP_WBITS = 4,
  localparam int unsigned MAP_WIDTH = 1 << MAP_WBITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [MAP_WBITS-1:0]          wr_addr,
  input  wall_id_t                      wr_data,
  input  logic                          load_en,
  input  wall_id_t [MAP_WIDTH-1:0]      load_row,
  input  logic [MAP_WBITS-1:0]          rd_addr,
  output wall_id_t                      rd_data,
  output wall_id_t [MAP_WIDTH-1:0]      row_o
);

  wall_id_t [MAP_WIDTH-1:0] mem_q, mem_d;

  // Bulk load wins over a single-cell write.
  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d = load_row;
    end else if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign row_o   = mem_q;

endmodule

// File: rtl/map_row_prefetch.sv
// Fetches next scanline's map row during hblank and promotes it at line start.
// Optional MAP_PREFETCH_STATS_EN adds o_miss_count (saturating aborted-fetch count).
module map_row_prefetch
  import map_row_prefetch_pkg::*;
#(
  parameter int unsigned H_VIEW    = 640,
  parameter int unsigned MAP_WBITS = 4,
  parameter int unsigned MAP_HBITS = 4,
  parameter int unsigned MAP_SCALE = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [POS_W-1:0]  hpos,
  input  logic [POS_W-1:0]  vpos,
  map_row_prefetch_if.master bus,
  output logic              o_busy
`ifdef MAP_PREFETCH_STATS_EN
  ,
  output logic [7:0]        o_miss_count
`endif
);

  localparam int unsigned          MAP_WIDTH  = map_width(MAP_WBITS);
  localparam int unsigned          OVL_H      = ovl_h(MAP_HBITS, MAP_SCALE);
  localparam logic [MAP_WBITS-1:0] LAST_COL   = MAP_WBITS'(MAP_WIDTH - 1);
  localparam logic [POS_W-1:0]     H_VIEW_POS = POS_W'(H_VIEW);

  state_t               state_q, state_d;
  logic [MAP_WBITS-1:0] col_q, col_d;
  logic [MAP_HBITS-1:0] fetch_tag_q, fetch_tag_d;
  logic [MAP_HBITS-1:0] disp_tag_q, disp_tag_d;
  logic                 ovl_valid_q, ovl_valid_d;
  logic                 rom_req_q, rom_req_d;
  logic                 busy_q, busy_d;

  logic                 fb_wr_en;
  logic                 promote;
  logic                 miss_ev;

  logic [POS_W-1:0]     nv;
  logic [MAP_HBITS-1:0] target_row;
  logic                 line_start;
  logic                 hblank_start;
  logic                 nv_in_map;
  logic                 line_past_map;

  assign nv            = vpos + POS_W'(1);
  assign target_row    = nv[MAP_SCALE +: MAP_HBITS];
  assign line_start    = (hpos == '0);
  assign hblank_start  = (hpos == H_VIEW_POS);
  assign nv_in_map     = (32'(nv) < OVL_H);
  assign line_past_map = (32'(vpos) >= OVL_H);

  // Next-state and buffer control; line start outranks any grant in the same cycle.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    fetch_tag_d = fetch_tag_q;
    disp_tag_d  = disp_tag_q;
    ovl_valid_d = ovl_valid_q;
    fb_wr_en    = 1'b0;
    promote     = 1'b0;
    miss_ev     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (line_start) begin
          if (line_past_map) begin
            ovl_valid_d = 1'b0;
          end
        end else if (hblank_start && nv_in_map &&
                     ((disp_tag_q != target_row) || !ovl_valid_q)) begin
          state_d     = ST_FETCH;
          fetch_tag_d = target_row;
          col_d       = '0;
        end
      end

      ST_FETCH: begin
        if (line_start) begin
          state_d     = ST_IDLE;
          ovl_valid_d = 1'b0;
          miss_ev     = 1'b1;
        end else if (bus.i_rom_gnt) begin
          fb_wr_en = 1'b1;
          if (col_q == LAST_COL) begin
            state_d = ST_READY;
          end else begin
            col_d = col_q + MAP_WBITS'(1);
          end
        end
      end

      ST_READY: begin
        if (line_start) begin
          state_d     = ST_IDLE;
          promote     = 1'b1;
          disp_tag_d  = fetch_tag_q;
          ovl_valid_d = 1'b1;
        end else if (hblank_start) begin
          // A stale, never-promoted row is thrown away.
          if (nv_in_map) begin
            state_d     = ST_FETCH;
            fetch_tag_d = target_row;
            col_d       = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_req_d = (state_d == ST_FETCH);
  assign busy_d    = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      fetch_tag_q <= '0;
      disp_tag_q  <= '0;
      ovl_valid_q <= 1'b0;
      rom_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      fetch_tag_q <= fetch_tag_d;
      disp_tag_q  <= disp_tag_d;
      ovl_valid_q <= ovl_valid_d;
      rom_req_q   <= rom_req_d;
      busy_q      <= busy_d;
    end
  end

  wall_id_t [MAP_WIDTH-1:0] fetch_row;
  wall_id_t [MAP_WIDTH-1:0] disp_row_unused;
  wall_id_t                 fetch_rd_unused;
  wall_id_t                 disp_rd;

  map_row_buffer #(.MAP_WBITS(MAP_WBITS)) u_fetch_buf (
    .clk      (clk),
    .rst_n    (reset_n),
    .wr_en    (fb_wr_en),
    .wr_addr  (col_q),
    .wr_data  (bus.i_rom_val),
    .load_en  (1'b0),
    .load_row ('0),
    .rd_addr  (col_q),
    .rd_data  (fetch_rd_unused),
    .row_o    (fetch_row)
  );

  map_row_buffer #(.MAP_WBITS(MAP_WBITS)) u_disp_buf (
    .clk      (clk),
    .rst_n    (reset_n),
    .wr_en    (1'b0),
    .wr_addr  ('0),
    .wr_data  ('0),
    .load_en  (promote),
    .load_row (fetch_row),
    .rd_addr  (bus.i_ovl_col),
    .rd_data  (disp_rd),
    .row_o    (disp_row_unused)
  );

  assign bus.o_rom_req   = rom_req_q;
  assign bus.o_rom_col   = col_q;
  assign bus.o_rom_row   = fetch_tag_q;
  assign bus.o_ovl_valid = ovl_valid_q;
  assign bus.o_ovl_val   = ovl_valid_q ? disp_rd : '0;
  assign o_busy          = busy_q;

`ifdef MAP_PREFETCH_STATS_EN
  logic [7:0] miss_q, miss_d;

  // Saturating count of fetches starved past line start.
  always_comb begin
    miss_d = miss_q;
    if (miss_ev && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign o_miss_count = miss_q;
`else
  logic miss_unused;
  assign miss_unused = miss_ev;
`endif

endmodule

// File: tb/tb_map_row_prefetch.sv
// Self-checking bench for map_row_prefetch: line-by-line vector table plus
// hand-written restart and mid-fetch reset sequences.
`timescale 1ns/1ps
module tb_map_row_prefetch;
  import map_row_prefetch_pkg::*;

  localparam int unsigned WB = 4;
  localparam int unsigned HB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       busy;
`ifdef MAP_PREFETCH_STATS_EN
  logic [7:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  map_row_prefetch_if #(.MAP_WBITS(WB), .MAP_HBITS(HB)) bus ();

  map_row_prefetch #(
    .H_VIEW    (640),
    .MAP_WBITS (WB),
    .MAP_HBITS (HB),
    .MAP_SCALE (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hpos    (hpos),
    .vpos    (vpos),
    .bus     (bus),
    .o_busy  (busy)
`ifdef MAP_PREFETCH_STATS_EN
    ,
    .o_miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: row 1 holds col%4.
  function automatic logic [1:0] rom_f(input logic [3:0] row, input logic [3:0] col);
    return 2'(32'(col) + 2 * 32'(row) + 2);
  endfunction

  always_comb bus.i_rom_val = rom_f(bus.o_rom_row, bus.o_rom_col);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line start at hpos=0, then sweep the overlay across every column.
  task automatic line_start_sweep(input logic [9:0] v, input bit exp_valid, input int row);
    hpos = '0;
    vpos = v;
    bus.i_rom_gnt = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    for (int c = 0; c < 16; c++) begin
      hpos = 10'(1 + c);
      bus.i_ovl_col = 4'(c);
      exp_q.push_back(exp_valid ? rom_f(4'(row), 4'(c)) : 2'd0);
      @(negedge clk);
      if (c == 0) check($sformatf("ovl_valid v%0d", v), 32'(bus.o_ovl_valid), 32'(exp_valid));
      check($sformatf("ovl_val v%0d col%0d", v, c), 32'(bus.o_ovl_val), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
  endtask

  // hblank: mode 0 = no grant, 1 = continuous, 2 = grant on even hpos.
  task automatic hblank(input logic [9:0] v, input int mode, input int len,
                        input int frow, input int exp_req, input int exp_ready);
    int reqs = 0;
    int ready_h = 0;
    int ecol = 0;
    for (int i = 0; i < len; i++) begin
      logic [9:0] h;
      h = 10'(640 + i);
      hpos = h;
      vpos = v;
      bus.i_rom_gnt = (mode == 1) || ((mode == 2) && !h[0]);
      @(negedge clk);
      if (bus.o_rom_req) begin
        reqs++;
        check($sformatf("rom_addr v%0d h%0d", v, h), 32'({bus.o_rom_row, bus.o_rom_col}),
              32'({4'(frow), 4'(ecol)}));
        if (bus.i_rom_gnt) ecol++;
      end else if (busy && (reqs > 0) && (ready_h == 0)) begin
        ready_h = int'(h);
      end
      @(posedge clk); #1;
    end
    check($sformatf("req_cycles v%0d", v), 32'(reqs), 32'(exp_req));
    check($sformatf("ready_hpos v%0d", v), 32'(ready_h), 32'(exp_ready));
  endtask

  typedef struct {
    logic [9:0] v;
    int         mode;
    int         len;
    bit         exp_valid;
    int         disp_row;
    int         fetch_row;
    int         exp_req;
    int         exp_ready;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    bit   hit;

    tbl[0]  = '{10'd7,   1, 20, 1'b0, 0, 1, 16, 657};
    tbl[1]  = '{10'd8,   1, 20, 1'b1, 1, 0,  0,   0};
    tbl[2]  = '{10'd9,   1, 20, 1'b1, 1, 0,  0,   0};
    tbl[3]  = '{10'd14,  1, 20, 1'b1, 1, 0,  0,   0};
    tbl[4]  = '{10'd15,  0, 20, 1'b1, 1, 2, 19,   0};
    tbl[5]  = '{10'd16,  1, 20, 1'b0, 0, 2, 16, 657};
    tbl[6]  = '{10'd17,  1, 20, 1'b1, 2, 0,  0,   0};
    tbl[7]  = '{10'd23,  2, 40, 1'b1, 2, 3, 32, 673};
    tbl[8]  = '{10'd24,  1, 20, 1'b1, 3, 0,  0,   0};
    tbl[9]  = '{10'd127, 1, 20, 1'b1, 3, 0, 16, 657};
    tbl[10] = '{10'd128, 1, 20, 1'b1, 0, 0,  0,   0};
    tbl[11] = '{10'd129, 1, 20, 1'b0, 0, 0,  0,   0};

    reset_n = 1'b0;
    hpos = '0;
    vpos = '0;
    bus.i_rom_gnt = 1'b0;
    bus.i_ovl_col = '0;
    @(negedge clk);
    check("reset req",   32'(bus.o_rom_req),   32'd0);
    check("reset busy",  32'(busy),            32'd0);
    check("reset valid", 32'(bus.o_ovl_valid), 32'd0);
    check("reset val",   32'(bus.o_ovl_val),   32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      line_start_sweep(tbl[i].v, tbl[i].exp_valid, tbl[i].disp_row);
      hblank(tbl[i].v, tbl[i].mode, tbl[i].len, tbl[i].fetch_row, tbl[i].exp_req, tbl[i].exp_ready);
    end
`ifdef MAP_PREFETCH_STATS_EN
    check("miss_count after table", 32'(miss_count), 32'd1);
`endif

    // Stale READY row restarted by the next hblank without a line start.
    line_start_sweep(10'd40, 1'b0, 0);
    hblank(10'd40, 1, 20, 5, 16, 657);
    hblank(10'd47, 1, 20, 6, 16, 657);
    line_start_sweep(10'd48, 1'b1, 6);
    hblank(10'd48, 1, 20, 0, 0, 0);

    // Reset pulsed while the fetch sits at column 9.
    line_start_sweep(10'd55, 1'b1, 6);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      hpos = 10'(640 + i);
      vpos = 10'd55;
      bus.i_rom_gnt = 1'b1;
      bus.i_ovl_col = 4'd5;
      @(negedge clk);
      if (bus.o_rom_req && (bus.o_rom_col == 4'd9)) begin
        hit = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("midreset req",   32'(bus.o_rom_req),   32'd0);
        check("midreset busy",  32'(busy),            32'd0);
        check("midreset valid", 32'(bus.o_ovl_valid), 32'd0);
        check("midreset val",   32'(bus.o_ovl_val),   32'd0);
        check("midreset addr",  32'({bus.o_rom_row, bus.o_rom_col}), 32'd0);
`ifdef MAP_PREFETCH_STATS_EN
        check("midreset miss", 32'(miss_count), 32'd0);
`endif
      end
      @(posedge clk); #1;
    end
    check("midreset col9 reached", 32'(hit), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    line_start_sweep(10'd56, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/map_row_prefetch.md
Name: map_row_prefetch

Overview:
- Sits directly upstream of the map overlay stage. Gives the overlay conflict-free map data while the tracer keeps priority on the shared map ROM.
- During each hblank it fetches the whole map row that the next scanline's overlay will show, one cell per granted ROM cycle, into a fetch buffer.
- At line start the fetch buffer is promoted to a display buffer. The overlay then reads cells combinationally from the display buffer.

Parameters:
- H_VIEW, 640, first hpos of hblank; triggers the fetch.
- MAP_WBITS, 4, log2 map width (MAP_WIDTH = 1<<MAP_WBITS cells per row).
- MAP_HBITS, 4, log2 map height.
- MAP_SCALE, 3, log2 pixels per map cell in the overlay.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- hpos  in  10  current horizontal pixel position.
- vpos  in  10  current vertical line.
- o_rom_req  out  1  request for the map ROM port.
- i_rom_gnt  in  1  grant from the arbiter; the tracer has priority.
- o_rom_col  out  MAP_WBITS  column address presented to the ROM.
- o_rom_row  out  MAP_HBITS  row address presented to the ROM.
- i_rom_val  in  2  ROM data; valid in the same cycle as req&&gnt.
- i_ovl_col  in  MAP_WBITS  column requested by the overlay.
- o_ovl_val  out  2  cell value from the display buffer.
- o_ovl_valid  out  1  display buffer holds the current line's map row.
- o_busy  out  1  FSM is not IDLE.

Behaviour:
- Reset (async, reset_n=0) values:
  - State IDLE; col counter 0; both buffers all zero; display tag 0.
  - o_ovl_valid=0, o_rom_req=0, o_busy=0, o_ovl_val=0.
- Derived values:
  - nv = vpos+1, 10-bit, wraps naturally.
  - OVL_H = (1<<(MAP_HBITS+MAP_SCALE))+1.
  - target row = nv[MAP_SCALE+MAP_HBITS-1:MAP_SCALE].
- FSM IDLE -> FETCH:
  - Taken when hpos==H_VIEW and nv<OVL_H, and (display tag != target row or o_ovl_valid==0).
  - On entry: latch the target row into the fetch tag and clear the col counter.
  - If the target row already equals the display tag and the buffer is valid, stay IDLE; display is retained.
- FSM FETCH:
  - o_rom_req=1; o_rom_col = col counter; o_rom_row = fetch tag.
  - On req&&gnt, write i_rom_val to fetch buffer[col] and increment col.
  - On the grant at col==MAP_WIDTH-1, go to READY. The counter does not wrap.
  - With no grant, hold; the address stays stable.
- FSM READY: o_rom_req=0; wait.
- Line start (hpos==0), evaluated every line, with priority over any grant in that cycle:
  - READY: copy fetch buffer to display buffer, display tag := fetch tag, o_ovl_valid=1 next cycle, go to IDLE.
  - FETCH (starved by the tracer): abort to IDLE. The grant in that cycle is ignored. o_ovl_valid=0. Display contents unchanged. This counts as a miss.
  - IDLE: if nv-1 (the current line) >= OVL_H, set o_ovl_valid=0. Otherwise keep it.
- Overlay read: o_ovl_val = display buffer[i_ovl_col], purely combinational with zero latency. It returns 0 when o_ovl_valid=0.
- Latency: the fetch needs at least MAP_WIDTH granted cycles within hblank. With continuous grant, READY is reached MAP_WIDTH+1 cycles after hpos==H_VIEW.
- Simultaneous events: if hpos==H_VIEW coincides with READY (a stale, unswapped fetch), restart FETCH and discard the stale data.
- Reset mid-fetch: everything returns to reset values immediately; a partial row is never promoted.

Optional Feature:
- Macro: MAP_PREFETCH_STATS_EN.
- Defined: adds output o_miss_count[7:0], a saturating count (stops at 255) of aborted fetches. It is cleared only by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - MAP_WIDTH and OVL_H derivations.
  - State encoding: IDLE=2'd0, FETCH=2'd1, READY=2'd2.
  - The 2-bit wall-ID type.
- One sub-module, map_row_buffer:
  - MAP_WIDTH x 2-bit register array.
  - Single write port (en, addr, data) and a combinational read mux.
  - Bulk-load input used for the promote operation.
  - Instantiated twice: fetch and display buffers.

Test Plan:
- Continuous grant, vpos=7, ROM row 1 = cols 0..15 values (c%4):
  - hpos=640 -> FETCH with row 1; READY at hpos=657.
  - At hpos=0, vpos=8: o_ovl_valid=1; i_ovl_col=5 -> o_ovl_val=1.
- Lines vpos=8..14 (same row 1):
  - No o_rom_req asserted; display row is retained.
- Grant withheld for all of hblank:
  - At hpos=0: abort; o_ovl_valid=0; o_miss_count=1 with MAP_PREFETCH_STATS_EN.
- Grant toggled every other cycle:
  - Fetch completes in 32 cycles; data is correct on every column.
- vpos=128 (nv=129 >= OVL_H=129):
  - No fetch; o_ovl_valid drops at the next hpos==0.
- reset_n pulsed low at col=9 during FETCH:
  - All outputs zero immediately.
  - Display buffer reads 0 for every column afterwards.
